// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver.
// Holds the FSM state encoding used by shiftreg_sipo_rx.
package shiftreg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int SIPO_DEFAULT_W = 4;

endpackage : shiftreg_pkg

// File: rtl/shiftreg_sipo_rx.sv
// Serial-in/parallel-out receiver: LSB-first frames of DATA_W bits into a
// one-deep holding register with valid/ready handshake and a sticky overrun.
module shiftreg_sipo_rx
    import shiftreg_pkg::*;
#(
    parameter int DATA_W = SIPO_DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_start,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    input  logic              ovr_clr,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    // Only DATA_W-1 bits are kept: the bit that would fall out of the LSB
    // on the completing shift is never observable, the word is taken from word_s.
    logic [DATA_W-2:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                overrun_q, overrun_d;

    logic [DATA_W-1:0]   word_s;
    logic                word_done_s;
    logic                consume_s;
    logic                ovr_set_s;

    // Frame FSM, shift register and bit counter next-state logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        word_done_s = 1'b0;
        word_s      = {sin, shreg_q};
        if (sin_start) begin
            state_d  = SHIFT;
            shreg_d  = {(DATA_W-1){1'b0}};
            bitcnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (sin_valid) begin
                        shreg_d = word_s[DATA_W-1:1];
                        if (bitcnt_q == LAST_CNT) begin
                            word_done_s = 1'b1;
                            state_d     = IDLE;
                            bitcnt_d    = {CNT_W{1'b0}};
                        end else begin
                            bitcnt_d = bitcnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    bitcnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Holding register handshake and sticky overrun next-state logic.
    always_comb begin
        consume_s    = dout_valid_q & dout_ready;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovr_set_s    = 1'b0;
        if (word_done_s) begin
            if (!dout_valid_q || consume_s) begin
                dout_d       = word_s;
                dout_valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (consume_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        // A same-edge set beats the clear so a drop is never lost.
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bitcnt_q     <= {CNT_W{1'b0}};
            shreg_q      <= {(DATA_W-1){1'b0}};
            dout_q       <= {DATA_W{1'b0}};
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

endmodule : shiftreg_sipo_rx

// File: doc/shiftreg_sipo_rx.md
SHIFTREG_SIPO_RX -- requirements
Module: shiftreg_sipo_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 4, giving the word width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port sin_start, input, 1 bit: frame-start strobe, one cycle wide.
REQ-005 SHALL have port sin, input, 1 bit: serial data bit, sampled only when sin_valid=1.
REQ-006 SHALL have port sin_valid, input, 1 bit: bit strobe qualifying sin.
REQ-007 SHALL have port dout, output, DATA_W bits: received parallel word.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-009 SHALL have port dout_ready, input, 1 bit: consumer accepts dout when dout_valid=1.
REQ-010 SHALL have port ovr_clr, input, 1 bit: synchronous clear of the overrun flag.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag for a dropped word.

Function
REQ-012 SHALL use a two-state FSM with states IDLE and SHIFT, plus a shift register, a bit counter of width clog2(DATA_W), and an output holding register.
REQ-013 SHALL move to SHIFT and clear the shift register and bit counter on any cycle with sin_start=1, from either state.
REQ-014 SHALL ignore sin_valid in any cycle where sin_start=1, so start wins over a same-cycle bit.
REQ-015 SHALL ignore sin_valid while in IDLE.
REQ-016 SHALL, in SHIFT with sin_valid=1 and sin_start=0, shift right with sin entering the MSB (shreg <= {sin, shreg[DATA_W-1:1]}) and increment the bit counter.
REQ-017 SHALL treat the first received bit as the word LSB, matching the LSB-first output of the team's rotate-right shift register.
REQ-018 SHALL complete the frame on the DATA_W-th accepted bit; at that edge the assembled word SHALL be offered to the holding register and the FSM SHALL return to IDLE.
REQ-019 SHALL assert dout_valid on the cycle after the edge that samples the final bit (latency 1 clock).
REQ-020 SHALL consume the word on any edge where dout_valid=1 and dout_ready=1.
REQ-021 SHALL deassert dout_valid after a consume unless a new word loads on the same edge.
REQ-022 SHALL, when a word completes on the same edge as a consume, load the new word, keep dout_valid=1, and leave overrun unchanged.
REQ-023 SHALL, when a word completes while dout_valid=1 and dout_ready=0, drop the new word, keep dout unchanged, and set overrun=1.
REQ-024 SHALL hold overrun at 1 until an edge with ovr_clr=1; if that edge also sets overrun, set SHALL win.
REQ-025 SHALL, on a restart via sin_start mid-frame, discard the partial bits without asserting overrun or changing dout.
REQ-026 SHALL hold dout stable whenever dout_valid=1 and no consume occurs.

Reset
REQ-027 SHALL, while rst_n=0 and independent of clk, force FSM=IDLE, bit counter=0, shift register=0, dout=0, dout_valid=0, overrun=0.
REQ-028 SHALL abandon any frame in progress when reset asserts mid-frame.
REQ-029 SHALL treat the first rising clk edge after rst_n deasserts as a normal functional edge.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, SHIFT) in the shared package shiftreg_pkg.
REQ-031 SHALL be a single module with no sub-modules; the bit counter and holding register are inline.

Verification (DATA_W=4)
REQ-032 Basic frame: sin_start, then bits 1,0,1,1 with sin_valid, dout_ready=1 -> dout=4'b1101, dout_valid=1 for 1 cycle, overrun=0.
REQ-033 Gapped bits: same frame with 3 idle cycles between strobes -> dout=4'b1101 one cycle after the 4th strobe; idle-cycle sin values ignored.
REQ-034 Overrun: dout_ready=0, receive 4'hA then 4'h5 -> dout stays 4'hA, overrun=1; then ovr_clr pulse -> overrun=0.
REQ-035 Simultaneous completion and consume: dout_valid=1 (4'h3), last bit of 4'hC lands on the dout_ready=1 edge -> dout=4'hC, dout_valid stays 1, overrun=0.
REQ-036 Restart and start-wins: 2 bits, then sin_start together with sin_valid, then bits 0,1,1,0 -> dout=4'h6 and the same-cycle bit is ignored.
REQ-037 Reset mid-frame: assert rst_n=0 after 2 bits, between edges -> outputs zero immediately; the next full frame of 4'h9 -> dout=4'h9.
